// File: rtl/pl_hazard_ctrl.sv
// Pipeline hazard control in ID: load-use interlock, mul/div EX occupancy FSM,
// branch flush qualification, ID-stage operand forwarding and a stall-cycle counter.
module pl_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             id_muldiv,
  input  logic             id_taken,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       ern,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [4:0]       mrn,
  output logic             wpcir,
  output logic             flush,
  output logic             bubble,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, BUSY} state_t;

  localparam logic [3:0] MD_CNT_INIT = 4'(MD_LAT - 1);

  state_t           state_q, state_d;
  logic [3:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu;
  logic             busy_st;
  logic             stall;
  logic [1:0]       fwda_raw, fwdb_raw;

  assign lu = ewreg & em2reg & (ern != 5'd0) &
              ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    busy_st  = 1'b0;
    case (state_q)
      RUN: begin
        // A mul/div blocked by a load-use hazard waits in ID and issues later.
        if (!lu && id_muldiv) begin
          state_d  = BUSY;
          md_cnt_d = MD_CNT_INIT;
        end
      end
      BUSY: begin
        busy_st  = 1'b1;
        md_cnt_d = md_cnt_q - 4'd1;
        if (md_cnt_q == 4'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign stall       = lu | busy_st;
  assign stall_cnt_d = (stall && (stall_cnt_q != {CNT_W{1'b1}})) ?
                       stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RUN;
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwda_raw = (ewreg & ~em2reg & (ern != 5'd0) & (ern == rs))  ? 2'd1 :
                    (mwreg & ~mm2reg & (mrn != 5'd0) & (mrn == rs))  ? 2'd2 :
                    (mwreg &  mm2reg & (mrn != 5'd0) & (mrn == rs))  ? 2'd3 : 2'd0;
  assign fwdb_raw = (ewreg & ~em2reg & (ern != 5'd0) & (ern == rt))  ? 2'd1 :
                    (mwreg & ~mm2reg & (mrn != 5'd0) & (mrn == rt))  ? 2'd2 :
                    (mwreg &  mm2reg & (mrn != 5'd0) & (mrn == rt))  ? 2'd3 : 2'd0;

  // Control outputs are forced to their idle values while reset is held.
  assign wpcir     = ~resetn | ~stall;
  assign bubble    = resetn & stall;
  assign flush     = resetn & id_taken & ~stall;
  assign md_busy   = resetn & busy_st;
  assign fwda      = resetn ? fwda_raw : 2'd0;
  assign fwdb      = resetn ? fwdb_raw : 2'd0;
  assign stall_cnt = stall_cnt_q;

endmodule
